window_scan_ctrl: RTL and testbench
===================================

# window_scan_ctrl

Raster-scan sequencer that feeds 3x3 pixel windows to the first-order edge-detection and other neighbourhood operators in the image pipeline. It accepts a valid/ready pixel stream with a start-of-frame marker and buffers two image lines internally. It emits one registered 3x3 window per interior pixel, tagged with centre coordinates and frame/line markers. It also tracks frame progress and drives backpressure upstream.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 640, pixels per line; must be ≥ 3
- IMG_HEIGHT, 480, lines per frame; must be ≥ 3
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_pixel  in  DATA_WIDTH  input pixel
- in_valid  in  1  in_pixel valid
- in_sof  in  1  qualifies in_pixel as pixel (0,0) of a frame
- in_ready  out  1  pixel accepted when in_valid && in_ready
- win  out  9*DATA_WIDTH  window element k at bits [k*DATA_WIDTH +: DATA_WIDTH]; row-major, k=0 top-left, k=4 centre, k=8 bottom-right
- win_valid  out  1  win and its tags valid
- win_ready  in  1  downstream accepts window
- win_x  out  $clog2(IMG_WIDTH)  centre column
- win_y  out  $clog2(IMG_HEIGHT)  centre row
- win_sof  out  1  first window of frame (centre (1,1))
- win_eol  out  1  last window of a line (win_x = IMG_WIDTH-2)
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  high in SCAN or DONE

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: accepted pixels without in_sof are dropped. An accepted pixel with in_sof becomes (0,0); col=1, row=0; go to SCAN.
- SCAN: each accepted pixel is written at column col to the line buffers (two RAMs, depth IMG_WIDTH, rows r-1 and r-2). It is shifted into a 3x3 register array together with the buffered pixels from the same column.
- col wraps IMG_WIDTH-1→0, and row increments on each wrap.
- Window emitted for accepted pixel (c,r) only if c≥2 and r≥2. Centre = (c-1, r-1). The bottom-right element is that pixel. Output count per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Acceptance of pixel (IMG_WIDTH-1, IMG_HEIGHT-1) → DONE. DONE lasts 1 cycle with frame_done=1, then → IDLE.
- Output register: loaded on acceptance of an emitting pixel. win_valid is held until win_valid && win_ready.
- in_ready = (state≠DONE) && (!win_valid || win_ready).
- Arithmetic: counters are unsigned and wrap only at the image bounds. No pixel values are modified.
- An in_sof in SCAN is handled per Configuration.

## Timing
- Latency: win_valid rises the cycle after the emitting pixel is accepted.
- Throughput is 1 window/cycle when win_ready is held high.
- frame_done is asserted in the cycle after the last pixel is accepted, coincident with the last window's win_valid.
- Backpressure: with win_valid=1 and win_ready=0, in_ready=0. win, win_x, win_y, win_sof and win_eol are held stable.
- Gaps on in_valid produce no output and do not change state.
- Reset (any cycle, including mid-frame): state=IDLE, counters=0, win=0, win_valid=0, win_x=0, win_y=0, win_sof=0, win_eol=0, frame_done=0, busy=0. in_ready=1 the cycle after reset deasserts. A pending window is discarded. Line-buffer contents are not cleared, because rows 0 and 1 are rewritten before they are read.
- in_valid while in_ready=0 is not accepted; the source holds the pixel.

## Configuration
- SOF_RESYNC_EN defined: an accepted in_sof in SCAN restarts the frame. That pixel becomes (0,0), with col=1 and row=0. An already-registered window still completes its handshake. No frame_done is pulsed for the aborted frame.
- SOF_RESYNC_EN undefined: in_sof is ignored in SCAN and the pixel is treated as a normal pixel. Resync is only possible via IDLE.

## Test plan
- IMG_WIDTH=5, IMG_HEIGHT=4, pixel = 10*r+c, win_ready=1 → 6 windows.
  - First window = {0,1,2,10,11,12,20,21,22}, win_x=1, win_y=1, win_sof=1.
  - Last window = centre (3,2), win_eol=1.
  - frame_done pulses once, in the same cycle as the last win_valid.
- Same frame with win_ready low for 3 cycles while win_valid=1 → in_ready=0 for those cycles, win held stable, all 6 windows delivered in order.
- 3 pixels without in_sof in IDLE, then the frame → the junk pixels are dropped and the output is identical to the first scenario.
- Same frame with in_valid toggling every cycle → identical windows; each win_valid follows an accepted pixel by 1 cycle.
- rst pulsed after pixel (2,2) is accepted → next cycle win_valid=0 and busy=0; a fresh frame then produces the output of the first scenario.
- in_sof asserted on pixel (2,1):
  - Defined: restart; exactly 6 windows counted from the new (0,0).
  - Undefined: the marker is ignored; 6 windows and frame_done at the original position.

Source files
------------

// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: raster-scan 3x3 window sequencer.
// Two line buffers hold rows r-1 and r-2. A 3x2 tap array holds the two
// previous columns, and the incoming column completes the window.
// The result is registered with a valid/ready handshake.
// Optional feature macro: SOF_RESYNC_EN (an in_sof seen during SCAN restarts the frame).
module window_scan_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_pixel,
  input  logic                          in_valid,
  input  logic                          in_sof,
  output logic                          in_ready,
  output logic [9*DATA_WIDTH-1:0]       win,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
  output logic                          win_sof,
  output logic                          win_eol,
  output logic                          frame_done,
  output logic                          busy
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0] col, wcol;
  logic [YW-1:0] row;
  logic          acc, start, resync, restart, take, emit, last;

  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];  // row r-1
  logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];  // row r-2
  logic [DATA_WIDTH-1:0] tap [3][2];       // [row][0]=column c-2, [row][1]=column c-1
  logic [DATA_WIDTH-1:0] newcol [3];
  logic [9*DATA_WIDTH-1:0] win_nxt;

  assign acc   = in_valid && in_ready;
  assign start = acc && (state == S_IDLE) && in_sof;
`ifdef SOF_RESYNC_EN
  assign resync = acc && (state == S_SCAN) && in_sof;
`else
  assign resync = 1'b0;
`endif
  assign restart = start || resync;
  // Any pixel that enters the scan, including the (0,0) pixel that opens the frame
  assign take = start || (acc && (state == S_SCAN));
  assign wcol = restart ? '0 : col;
  assign emit = take && !restart && (col >= XW'(2)) && (row >= YW'(2));
  assign last = take && !restart && (col == X_LAST) && (row == Y_LAST);

  // Current column: buffered rows on top, incoming pixel at the bottom
  always_comb begin
    newcol[0] = lb2[wcol];
    newcol[1] = lb1[wcol];
    newcol[2] = in_pixel;
    win_nxt   = '0;
    for (int r = 0; r < 3; r++) begin
      win_nxt[(3*r+0)*DATA_WIDTH +: DATA_WIDTH] = tap[r][0];
      win_nxt[(3*r+1)*DATA_WIDTH +: DATA_WIDTH] = tap[r][1];
      win_nxt[(3*r+2)*DATA_WIDTH +: DATA_WIDTH] = newcol[r];
    end
  end

  // Line buffers shift down one row at the written column; rows 0/1 are rewritten before use, so no reset
  always_ff @(posedge clk) begin
    if (take) begin
      lb1[wcol] <= in_pixel;
      lb2[wcol] <= lb1[wcol];
    end
  end

  // Horizontal tap shift; stale taps at line start are never emitted because c>=2 is required
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        tap[r][0] <= '0;
        tap[r][1] <= '0;
      end
    end else if (take) begin
      for (int r = 0; r < 3; r++) begin
        tap[r][0] <= tap[r][1];
        tap[r][1] <= newcol[r];
      end
    end
  end

  // Column/row position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (restart) begin
      col <= XW'(1);
      row <= '0;
    end else if (take) begin
      if (col == X_LAST) begin
        col <= '0;
        row <= (row == Y_LAST) ? '0 : row + YW'(1);
      end else begin
        col <= col + XW'(1);
      end
    end
  end

  // Output register: load on an emitting pixel, drop valid once the window is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      win       <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      win_sof   <= 1'b0;
      win_eol   <= 1'b0;
    end else if (emit) begin
      win       <= win_nxt;
      win_valid <= 1'b1;
      win_x     <= col - XW'(1);
      win_y     <= row - YW'(1);
      win_sof   <= (col == XW'(2)) && (row == YW'(2));
      win_eol   <= (col == X_LAST);
    end else if (win_valid && win_ready) begin
      win_valid <= 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and state-derived outputs
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    busy       = 1'b0;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !win_valid || win_ready;
        if (start) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        busy     = 1'b1;
        in_ready = !win_valid || win_ready;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl (5x4 image).
// Expected windows are cut straight out of a stored image array;
// per-pixel emit/last flags come from the pixel's (col,row) position.
module tb_window_scan_ctrl;
  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   in_pixel = '0;
  logic            in_valid = 1'b0;
  logic            in_sof = 1'b0;
  logic            in_ready;
  logic [9*DW-1:0] win;
  logic            win_valid;
  logic            win_ready = 1'b1;
  logic [2:0]      win_x;
  logic [1:0]      win_y;
  logic            win_sof, win_eol, frame_done, busy;

  always #5 clk = ~clk;

  window_scan_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .win(win), .win_valid(win_valid), .win_ready(win_ready),
    .win_x(win_x), .win_y(win_y), .win_sof(win_sof), .win_eol(win_eol),
    .frame_done(frame_done), .busy(busy));

  typedef struct { logic [DW-1:0] pix; bit sof; bit emit; bit last; } stim_t;
  typedef struct { logic [9*DW-1:0] w; logic [2:0] x; logic [1:0] y; bit sof; bit eol; } wexp_t;

  logic [DW-1:0]   img [H][W];
  stim_t           stim [$];
  wexp_t           exp_q [$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [9*DW-1:0] first_w;
  logic [2:0]      first_x;
  logic [1:0]      first_y;
  logic            first_sof;
  int              nd;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_img(input bit rnd);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = rnd ? DW'($urandom) : DW'(10*r + c);
  endtask

  // Pixel stream: optional junk, optional aborted prefix (resync build), then the frame
  task automatic build(input int junk, input int extra_sof);
    stim_t s;
    wexp_t e;
    stim.delete();
    exp_q.delete();
    for (int j = 0; j < junk; j++) stim.push_back('{DW'($urandom), 1'b0, 1'b0, 1'b0});
`ifdef SOF_RESYNC_EN
    for (int p = 0; p < extra_sof; p++) stim.push_back('{img[p/W][p%W], p == 0, 1'b0, 1'b0});
`endif
    for (int p = 0; p < W*H; p++) begin
      s.pix  = img[p/W][p%W];
      s.sof  = (p == 0);
`ifndef SOF_RESYNC_EN
      if (p == extra_sof) s.sof = 1'b1;
`endif
      s.emit = (p%W >= 2) && (p/W >= 2);
      s.last = (p == W*H-1);
      stim.push_back(s);
    end
    for (int y = 1; y <= H-2; y++)
      for (int x = 1; x <= W-2; x++) begin
        e.w = '0;
        for (int k = 0; k < 9; k++) e.w[k*DW +: DW] = img[y-1+k/3][x-1+k%3];
        e.x   = 3'(x);
        e.y   = 2'(y);
        e.sof = (x == 1) && (y == 1);
        e.eol = (x == W-2);
        exp_q.push_back(e);
      end
  endtask

  // Drive the stream from a negedge; gap_mode 0 none/1 toggle/2 random,
  // bp_mode 0 ready/1 three low cycles on first window/2 random; stop_after<0 runs to completion
  task automatic run(input int gap_mode, input int bp_mode, input int stop_after, output int ndel);
    int    i = 0, cyc = 0, hold = 3, fd_cnt = 0;
    bit    exp_fd = 0, exp_wv = 0, held = 0, acc, gap, first = 1;
    logic [9*DW+6:0] hv = '0;
    wexp_t e;
    ndel = 0;
    forever begin
      gap = (gap_mode == 1) ? cyc[0] : (gap_mode == 2) ? ($urandom_range(99) < 30) : 1'b0;
      in_valid = (i < stim.size()) && !gap;
      in_pixel = (i < stim.size()) ? stim[i].pix : '0;
      in_sof   = (i < stim.size()) ? stim[i].sof : 1'b0;
      if (bp_mode == 1) begin
        win_ready = !(win_valid && hold > 0);
        if (win_valid && hold > 0) hold--;
      end else if (bp_mode == 2) win_ready = ($urandom_range(99) >= 30);
      else win_ready = 1'b1;
      #1;
      chk("frame_done", frame_done, exp_fd);
      if (frame_done) fd_cnt++;
      if (exp_fd) begin
        chk("done_busy", busy, 1);
        chk("done_in_ready", in_ready, 0);
      end
      if (exp_wv) chk("latency_win_valid", win_valid, 1);
      if (held) chk("held_window", {win_valid, win, win_x, win_y, win_sof, win_eol}, {1'b1, hv});
      held = win_valid && !win_ready;
      hv   = {win, win_x, win_y, win_sof, win_eol};
      if (held) chk("bp_in_ready", in_ready, 0);
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) chk("extra_window", win_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("win", win, e.w);
          chk("win_tags", {win_x, win_y, win_sof, win_eol}, {e.x, e.y, e.sof, e.eol});
          ndel++;
          if (first) begin
            first_w = win; first_x = win_x; first_y = win_y; first_sof = win_sof;
            first = 0;
          end
        end
      end
      acc    = in_valid && in_ready;
      exp_fd = acc && stim[i].last;
      exp_wv = acc && stim[i].emit;
      if (acc) i++;
      cyc++;
      @(negedge clk);
      if (stop_after >= 0 && i >= stop_after) break;
      if (stop_after < 0 && i == stim.size() && !exp_fd && !exp_wv && !win_valid) break;
      if (cyc > 3000) begin
        n_cmp++; n_err++;
        $error("FAIL timeout: observed %0d pixels accepted expected %0d", i, stim.size());
        break;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (stop_after < 0) begin
      #1;
      chk("windows_left", exp_q.size(), 0);
      chk("frame_done_pulses", fd_cnt, 1);
      chk("idle_busy", busy, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win", win, 0);
    chk("rst_tags", {win_x, win_y, win_sof, win_eol}, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Reference frame 10*r+c, free-flowing
    fill_img(0);
    build(0, -1);
    run(0, 0, -1, nd);
    chk("ref_count", nd, 6);
    chk("ref_first_win", first_w, 72'h161514_0c0b0a_020100);
    chk("ref_first_tags", {first_x, first_y, first_sof}, {3'd1, 2'd1, 1'b1});

    // Three cycles of downstream stall on the first window
    build(0, -1);
    run(0, 1, -1, nd);
    chk("bp_count", nd, 6);

    // Junk pixels in IDLE are dropped
    build(3, -1);
    run(0, 0, -1, nd);
    chk("junk_count", nd, 6);
    chk("junk_first_win", first_w, 72'h161514_0c0b0a_020100);

    // in_valid toggling every cycle
    build(0, -1);
    run(1, 0, -1, nd);
    chk("gap_count", nd, 6);

    // Reset right after pixel (2,2) is accepted
    build(0, -1);
    run(0, 0, 13, nd);
    chk("pre_rst_win_valid", win_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_win_valid", win_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_frame_done", frame_done, 0);
    @(negedge clk);
    build(0, -1);
    run(0, 0, -1, nd);
    chk("post_rst_count", nd, 6);
    chk("post_rst_first_win", first_w, 72'h161514_0c0b0a_020100);

    // in_sof on pixel (2,1): restart or ignored depending on build
    build(0, W + 2);
    run(0, 0, -1, nd);
    chk("sof_mid_count", nd, 6);

    // Random images with random gaps and stalls
    for (int f = 0; f < 4; f++) begin
      fill_img(1);
      build($urandom_range(2), -1);
      run(2, 2, -1, nd);
      chk("rand_count", nd, 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
